instr_fetch: RTL and testbench

- IF stage of the single-issue MIPS pipeline.
- Owns the program counter and drives the word address into the combinational instruction ROM.
- Captures the returned instruction into the IF/ID pipeline register consumed by decode.
- Supports stall from hazard logic, redirect from branch/jump resolution, and a sticky fault on a misaligned redirect.

---
 rtl/mips_pkg.sv | 10 +
 rtl/pc_reg.sv | 32 +++
 rtl/instr_fetch.sv | 82 ++++++++
 tb/tb_instr_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and constants
package mips_pkg;
    localparam int MIPS_WORD_W = 32;
    localparam logic [MIPS_WORD_W-1:0] MIPS_NOP = 32'h0000_0000;

    typedef enum logic {
        RUN,
        FAULT
    } fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with next-pc selection and redirect alignment check
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [MIPS_WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frozen,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [MIPS_WORD_W-1:0] redirect_pc,
    output logic [MIPS_WORD_W-1:0] pc,
    output logic                   redirect_misaligned
);

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // A misaligned target never reaches the pc, so pc[1:0] stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (frozen || redirect_misaligned) begin
            pc <= pc;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (!stall) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: pc, ROM addressing, IF/ID register, fault FSM, fetch counter
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [MIPS_WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                     CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [MIPS_WORD_W-1:0] redirect_pc,
    output logic [MIPS_WORD_W-1:0] rom_address,
    input  logic [MIPS_WORD_W-1:0] rom_instruction,
    output logic                   if_id_valid,
    output logic [MIPS_WORD_W-1:0] if_id_instr,
    output logic [MIPS_WORD_W-1:0] if_id_pc,
    output logic [MIPS_WORD_W-1:0] if_id_pc_plus4,
    output logic                   fetch_fault,
    output logic [CNT_W-1:0]       fetch_count
);

    fetch_state_t           state;
    logic [MIPS_WORD_W-1:0] pc;
    logic                   redirect_misaligned;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk                 (clk),
        .rst                 (rst),
        .frozen              (state == FAULT),
        .stall               (stall),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .pc                  (pc),
        .redirect_misaligned (redirect_misaligned)
    );

    assign rom_address = {2'b00, pc[MIPS_WORD_W-1:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            if_id_valid    <= 1'b0;
            if_id_instr    <= MIPS_NOP;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            fetch_fault    <= 1'b0;
            fetch_count    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_misaligned) begin
                        state       <= FAULT;
                        fetch_fault <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        // Squash the wrong-path fetch; redirect beats a concurrent stall.
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_instr    <= rom_instruction;
                        if_id_pc       <= pc;
                        if_id_pc_plus4 <= pc + 32'd4;
                        if_id_valid    <= 1'b1;
                        if (fetch_count != {CNT_W{1'b1}}) begin
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if_id_valid <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a behavioural model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] rom_address, rom_instruction;
    logic        if_id_valid, fetch_fault;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;

    logic [31:0] rom_address_s, rom_instruction_s;
    logic        if_id_valid_s, fetch_fault_s;
    logic [31:0] if_id_instr_s, if_id_pc_s, if_id_pc_plus4_s;
    logic [1:0]  fetch_count_s;

    int total = 0;
    int bad = 0;

    // Reference state, advanced once per clock from the behavioural rules.
    logic [31:0] m_pc, m_instr, m_ifpc, m_plus4, m_cnt;
    logic        m_valid, m_fault, m_faulted;
    logic [1:0]  m_cnt2;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] idx);
        case (idx)
            32'd0:   return 32'h2003AAAA;
            32'd1:   return 32'h20245555;
            32'd2:   return 32'h00400820;
            default: return (idx * 32'h9E3779B9) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    always_comb rom_instruction   = rom_fn(rom_address);
    always_comb rom_instruction_s = rom_fn(rom_address_s);

    instr_fetch #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    instr_fetch #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .rom_address     (rom_address_s),
        .rom_instruction (rom_instruction_s),
        .if_id_valid     (if_id_valid_s),
        .if_id_instr     (if_id_instr_s),
        .if_id_pc        (if_id_pc_s),
        .if_id_pc_plus4  (if_id_pc_plus4_s),
        .fetch_fault     (fetch_fault_s),
        .fetch_count     (fetch_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic st, input logic rv, input logic [31:0] rpc);
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 32'h0;
            m_plus4 = 32'h0; m_fault = 1'b0; m_cnt = 32'h0; m_cnt2 = 2'd0;
            m_faulted = 1'b0;
        end else if (m_faulted) begin
            m_valid = 1'b0;
        end else if (rv && (rpc % 4 != 0)) begin
            m_faulted = 1'b1; m_fault = 1'b1; m_valid = 1'b0;
        end else if (rv) begin
            m_pc = rpc; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = rom_fn(m_pc / 4);
            m_ifpc  = m_pc;
            m_plus4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
    endtask

    task automatic check_all();
        check("rom_address", rom_address, m_pc / 4);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc", if_id_pc, m_ifpc);
        check("if_id_pc_plus4", if_id_pc_plus4, m_plus4);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        check("fetch_count", fetch_count, m_cnt);
        check("fetch_count_sat", {30'b0, fetch_count_s}, {30'b0, m_cnt2});
        check("sat_if_id_pc", if_id_pc_s, m_ifpc);
    endtask

    task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] rpc);
        rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
        model_update(r, st, rv, rpc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] frozen_addr;
        logic [31:0] rpc;
        logic        r, st, rv;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_rom_address", rom_address, 32'h0);
        check("reset_valid", {31'b0, if_id_valid}, 32'h0);

        // Program start
        step(0, 0, 0, 0);
        check("start_instr0", if_id_instr, 32'h2003AAAA);
        check("start_valid0", {31'b0, if_id_valid}, 32'h1);
        check("start_addr1", rom_address, 32'h1);
        step(0, 0, 0, 0);
        check("start_instr1", if_id_instr, 32'h20245555);
        check("start_pc1", if_id_pc, 32'h4);

        // Stall for two cycles while if_id_pc=4
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("stall_addr", rom_address, 32'h2);
        check("stall_pc", if_id_pc, 32'h4);
        check("stall_count", fetch_count, 32'h2);
        step(0, 0, 0, 0);
        check("release_pc", if_id_pc, 32'h8);
        check("release_plus4", if_id_pc_plus4, 32'hC);
        check("release_instr", if_id_instr, 32'h00400820);
        check("release_count", fetch_count, 32'h3);

        // Redirect beats stall
        step(0, 1, 1, 32'h40);
        check("redir_valid", {31'b0, if_id_valid}, 32'h0);
        check("redir_addr", rom_address, 32'h10);
        step(0, 0, 0, 0);
        check("redir_pc", if_id_pc, 32'h40);
        check("redir_valid_after", {31'b0, if_id_valid}, 32'h1);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", if_id_pc_plus4, 32'h0);
        step(0, 0, 0, 0);
        check("wrap_next_pc", if_id_pc, 32'h0);
        check("sat_count", {30'b0, fetch_count_s}, 32'h3);

        // Reset mid-run with pc=0x20 and a valid instruction held
        step(0, 0, 1, 32'h1C);
        step(0, 0, 0, 0);
        check("pre_rst_addr", rom_address, 32'h8);
        step(1, 0, 0, 0);
        check("midrst_valid", {31'b0, if_id_valid}, 32'h0);
        check("midrst_count", fetch_count, 32'h0);
        step(0, 0, 0, 0);
        check("midrst_pc", if_id_pc, 32'h0);

        // Misaligned redirect, then stall/redirect toggling is ignored
        frozen_addr = rom_address;
        step(0, 0, 1, 32'h42);
        check("fault_flag", {31'b0, fetch_fault}, 32'h1);
        check("fault_valid", {31'b0, if_id_valid}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1'($urandom), 1'($urandom), $urandom);
            check("fault_frozen_addr", rom_address, frozen_addr);
        end
        step(1, 0, 0, 0);
        check("fault_clear", {31'b0, fetch_fault}, 32'h0);
        check("fault_clear_addr", rom_address, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 25);
            rv = ($urandom_range(0, 99) < 10);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if (m_faulted && $urandom_range(0, 9) == 0) r = 1'b1;
            step(r, st, rv, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
